// File: rtl/ahb_cache_arbiter.sv
// Shares one AHB-Lite master port between the I-cache and D-cache miss paths.
// One SINGLE transfer at a time; round-robin on simultaneous requests; misaligned requests never reach the bus.
module ahb_cache_arbiter #(
   parameter logic [3:0] I_HPROT = 4'b0010,
   parameter logic [3:0] D_HPROT = 4'b0011
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic [31:0] i_rdata,
   output logic        i_done,
   output logic        i_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_write,
   input  logic [2:0]  d_size,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, REJ} state_t;

   typedef struct packed {
      logic        sel_d;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   state_t      state;
   xfer_t       cur;
   xfer_t       nxt;
   logic [31:0] nxt_addr;
   logic        nxt_bad;
   logic        any_req;
   logic        last_d;
   logic        err_seen;
   logic        data_err;
   logic [31:0] data_rdata;

   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;

   function automatic logic [31:0] lanes(input logic [2:0] size, input logic [31:0] w);
      case (size)
         3'd0:    return {4{w[7:0]}};
         3'd1:    return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   // Arbitration: a tie goes to whichever port did not own the previous transfer.
   always_comb begin
      nxt       = '0;
      any_req   = i_req | d_req;
      nxt.sel_d = d_req & (~i_req | ~last_d);
      nxt.write = nxt.sel_d & d_write;
      nxt.size  = nxt.sel_d ? d_size : 3'd2;
      nxt.wdata = nxt.sel_d ? d_wdata : 32'h0;
      nxt_addr  = nxt.sel_d ? d_addr : i_addr;
      if (nxt.sel_d)
         nxt_bad = (d_size > 3'd2) ||
                   (d_size == 3'd1 && d_addr[0]) ||
                   (d_size == 3'd2 && d_addr[1:0] != 2'b00);
      else
         nxt_bad = (i_addr[1:0] != 2'b00);
   end

   // An ERROR seen during a wait state must survive until the final ready cycle.
   always_comb begin
      data_err   = HRESP | err_seen;
      data_rdata = (cur.write || data_err) ? 32'h0 : HRDATA;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cur      <= '0;
         last_d   <= 1'b1;
         err_seen <= 1'b0;
         i_gnt    <= 1'b0;
         i_done   <= 1'b0;
         i_err    <= 1'b0;
         i_rdata  <= 32'h0;
         d_gnt    <= 1'b0;
         d_done   <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= 32'h0;
         HADDR    <= 32'h0;
         HPROT    <= D_HPROT;
         HSIZE    <= 3'b010;
         HTRANS   <= TR_IDLE;
         HWDATA   <= 32'h0;
         HWRITE   <= 1'b0;
      end else begin
         i_gnt  <= 1'b0;
         i_done <= 1'b0;
         i_err  <= 1'b0;
         d_gnt  <= 1'b0;
         d_done <= 1'b0;
         d_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  cur      <= nxt;
                  last_d   <= nxt.sel_d;
                  err_seen <= 1'b0;
                  i_gnt    <= ~nxt.sel_d;
                  d_gnt    <= nxt.sel_d;
                  if (nxt_bad) begin
                     state <= REJ;
                  end else begin
                     state  <= ADDR;
                     HTRANS <= TR_NONSEQ;
                     HADDR  <= nxt_addr;
                     HWRITE <= nxt.write;
                     HSIZE  <= nxt.size;
                     HPROT  <= nxt.sel_d ? D_HPROT : I_HPROT;
                  end
               end
            end
            REJ: begin
               state <= IDLE;
               if (cur.sel_d) begin
                  d_done  <= 1'b1;
                  d_err   <= 1'b1;
                  d_rdata <= 32'h0;
               end else begin
                  i_done  <= 1'b1;
                  i_err   <= 1'b1;
                  i_rdata <= 32'h0;
               end
            end
            ADDR: begin
               if (HREADY) begin
                  state  <= DATA;
                  HTRANS <= TR_IDLE;
                  HWDATA <= lanes(cur.size, cur.wdata);
               end
            end
            DATA: begin
               if (!HREADY) begin
                  if (HRESP) err_seen <= 1'b1;
               end else begin
                  state <= IDLE;
                  if (cur.sel_d) begin
                     d_done  <= 1'b1;
                     d_err   <= data_err;
                     d_rdata <= data_rdata;
                  end else begin
                     i_done  <= 1'b1;
                     i_err   <= data_err;
                     i_rdata <= data_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_cache_arbiter.sv
// Directed plus randomized transfers checked cycle by cycle against a transaction-level model of the arbiter.
module tb_ahb_cache_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        i_err;
   logic        d_req;
   logic [31:0] d_addr;
   logic        d_write;
   logic [2:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_err;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic        HMASTLOCK;
   logic [3:0]  HPROT;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int          vectors = 0;
   int          miscompares = 0;
   bit          last_d;
   logic [31:0] exp_irdata;
   logic [31:0] exp_drdata;

   always #5 clk = ~clk;

   ahb_cache_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata),
      .i_done(i_done), .i_err(i_err),
      .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [2:0] sz, input logic [31:0] w);
      if (sz == 3'd0) return {4{w[7:0]}};
      if (sz == 3'd1) return {2{w[15:0]}};
      return w;
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, " HTRANS"}, 32'(HTRANS), 32'd0);
      chk({tag, " HADDR"}, HADDR, 32'h0);
      chk({tag, " HWRITE"}, 32'(HWRITE), 32'd0);
      chk({tag, " HSIZE"}, 32'(HSIZE), 32'd2);
      chk({tag, " HPROT"}, 32'(HPROT), 32'h3);
      chk({tag, " HWDATA"}, HWDATA, 32'h0);
      chk({tag, " HBURST"}, 32'(HBURST), 32'd0);
      chk({tag, " HMASTLOCK"}, 32'(HMASTLOCK), 32'd0);
      chk({tag, " pulses"}, 32'({i_gnt, i_done, i_err, d_gnt, d_done, d_err}), 32'd0);
      chk({tag, " i_rdata"}, i_rdata, 32'h0);
      chk({tag, " d_rdata"}, d_rdata, 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      HREADY = 1'b1;
      HRESP = 1'b0;
      step();
      step();
      reset = 1'b0;
      last_d = 1'b1;
      exp_irdata = 32'h0;
      exp_drdata = 32'h0;
   endtask

   // Caller has driven the request pins in the current (idle) cycle. Returns in the done cycle.
   task automatic xfer(input int wa, input int wd, input bit berr, input logic [31:0] rdv);
      bit          own_d, legal, wr, eerr;
      int          lat;
      logic [31:0] a, wexp, erd;
      logic [2:0]  sz;
      logic [3:0]  prot;
      own_d = (i_req && d_req) ? !last_d : d_req;
      if (own_d) begin
         a = d_addr; wr = d_write; sz = d_size; prot = 4'b0011;
         legal = (sz == 3'd0) || (sz == 3'd1 && !a[0]) || (sz == 3'd2 && a[1:0] == 2'b00);
      end else begin
         a = i_addr; wr = 1'b0; sz = 3'd2; prot = 4'b0010;
         legal = (a[1:0] == 2'b00);
      end
      wexp = lanes(sz, d_wdata);
      last_d = own_d;
      lat = legal ? 3 + wa + wd : 2;
      eerr = !legal || berr;
      erd = (eerr || wr) ? 32'h0 : rdv;
      for (int c = 1; c <= lat; c++) begin
         step();
         if (c == 1) begin
            if (own_d) d_req = 1'b0;
            else i_req = 1'b0;
         end
         chk("i_gnt", 32'(i_gnt), 32'(!own_d && c == 1));
         chk("d_gnt", 32'(d_gnt), 32'(own_d && c == 1));
         chk("i_done", 32'(i_done), 32'(!own_d && c == lat));
         chk("d_done", 32'(d_done), 32'(own_d && c == lat));
         chk("i_err", 32'(i_err), 32'(!own_d && c == lat && eerr));
         chk("d_err", 32'(d_err), 32'(own_d && c == lat && eerr));
         if (legal && c <= 1 + wa) begin
            chk("HTRANS addr", 32'(HTRANS), 32'd2);
            chk("HADDR", HADDR, a);
            chk("HWRITE", 32'(HWRITE), 32'(wr));
            chk("HSIZE", 32'(HSIZE), 32'(sz));
            chk("HPROT", 32'(HPROT), 32'(prot));
         end else begin
            chk("HTRANS idle", 32'(HTRANS), 32'd0);
         end
         if (legal && wr && c >= 2 + wa && c < lat)
            chk("HWDATA", HWDATA, wexp);
         if (c == lat) begin
            if (own_d) exp_drdata = erd;
            else exp_irdata = erd;
            chk("i_rdata", i_rdata, exp_irdata);
            chk("d_rdata", d_rdata, exp_drdata);
         end
         HRESP = 1'b0;
         HRDATA = $urandom;
         if (!legal) begin
            HREADY = 1'($urandom_range(0, 1));
         end else if (c <= 1 + wa) begin
            HREADY = (c == 1 + wa);
         end else if (c < lat) begin
            HREADY = (c == lat - 1);
            HRESP = berr && (c >= lat - 2);
            if (c == lat - 1) HRDATA = rdv;
         end else begin
            HREADY = 1'b1;
         end
      end
   endtask

   task automatic rand_req();
      int r;
      i_addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) i_addr[1:0] = 2'($urandom_range(1, 3));
      d_addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 2) == 0) d_addr[1:0] = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      d_size = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      d_write = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
   endtask

   initial begin
      reset = 1'b1; i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_addr = 32'h0; d_write = 1'b0; d_size = 3'd0; d_wdata = 32'h0;
      HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
      do_reset();
      check_reset_state("reset");

      // I-only aligned read
      i_addr = 32'h100; i_req = 1'b1;
      xfer(0, 0, 1'b0, 32'hDEAD_BEEF);

      // D byte write with lane replication
      d_addr = 32'h203; d_size = 3'd0; d_wdata = 32'hA5; d_write = 1'b1; d_req = 1'b1;
      xfer(0, 0, 1'b0, 32'h1234_5678);

      // Ties from reset: I, then D, then next tie to I
      do_reset();
      i_addr = 32'h400; d_addr = 32'h500; d_size = 3'd2; d_write = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      xfer(0, 0, 1'b0, $urandom);
      xfer(0, 0, 1'b0, $urandom);
      i_req = 1'b1; d_req = 1'b1;
      xfer(0, 0, 1'b0, $urandom);
      xfer(0, 0, 1'b0, $urandom);

      // Wait states: 2 in address phase, 3 in data phase
      d_addr = 32'h604; d_size = 3'd1; d_write = 1'b1; d_wdata = 32'h0000_BEEF; d_req = 1'b1;
      xfer(2, 3, 1'b0, $urandom);

      // Two-cycle ERROR response on a read
      d_addr = 32'h700; d_size = 3'd2; d_write = 1'b0; d_req = 1'b1;
      xfer(0, 1, 1'b1, 32'hCAFE_F00D);

      // Misaligned word rejected without a bus cycle
      d_addr = 32'h202; d_size = 3'd2; d_write = 1'b0; d_req = 1'b1;
      xfer(0, 0, 1'b0, $urandom);

      // Reset in the middle of a data phase
      d_addr = 32'h300; d_size = 3'd2; d_write = 1'b0; d_req = 1'b1;
      step();
      d_req = 1'b0; HREADY = 1'b1;
      step();
      chk("mid HTRANS data", 32'(HTRANS), 32'd0);
      HREADY = 1'b0;
      step();
      reset = 1'b1; HREADY = 1'b1; HRDATA = 32'h5555_AAAA;
      step();
      reset = 1'b0;
      last_d = 1'b1; exp_irdata = 32'h0; exp_drdata = 32'h0;
      check_reset_state("mid-reset");
      step();
      chk("post-reset d_done", 32'(d_done), 32'd0);

      // Randomized mix of single and tied requests with random wait states and errors
      for (int k = 0; k < 60; k++) begin
         int mode;
         mode = $urandom_range(0, 2);
         rand_req();
         i_req = (mode != 1);
         d_req = (mode != 0);
         xfer($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 5) == 0, $urandom);
         if (mode == 2)
            xfer($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 5) == 0, $urandom);
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
